// File: rtl/clock_sweep_sequencer.sv
// ----------------------------------------------------------------------------
// clock_sweep_sequencer
//
// Steps a clock scaler through a small table of divisor values. Each table
// entry is held for a programmable number of scaled-clock ticks, and the sweep
// either stops after the last slot or wraps back to slot 0. A byte-wide
// register interface configures the table and controls the sweep.
//
// State table:
//   IDLE | not sequencing; divisor keeps whatever value it last had
//   LOAD | single cycle: drive table[slot] to the scaler, pulse divisor_load,
//        | reload the tick counter from HOLD
//   HOLD | count scaled-clock ticks; on terminal count advance, wrap or stop
//
// Register map (register_select_i):
//   0 SLOT_LO  W: latch low byte          R: table[slot_sel][7:0]
//   1 SLOT_HI  W: commit {data, lo} to    R: table[slot_sel][15:8]
//              table[slot_sel]
//   2 HOLD     R/W ticks per slot, 0 means 256
//   3 CONTROL  R/W bit0 run, bit1 loop, bits3:2 last_slot, bit7 irq_enable
//   4 STATUS   R: bit0 running, bits2:1 slot, bit7 irq_pending
//              W: any value clears irq_pending
//   5 SLOT_SEL R/W bits1:0
//   6,7        read as 0x00
//
// Ports:
//   input_clock_i      single clock, everything on its rising edge
//   reset_i            synchronous active-high reset
//   phi2_i             bus phase: low = read setup, high = write strobe
//   enabled_i          device selected
//   register_select_i  register index
//   rwb_i              0 = master writes, 1 = master reads
//   data_bus_r_i       write data from the master
//   data_bus_w_o       registered read data to the master
//   tick_i             one-cycle pulse per scaled-clock rising edge
//   divisor_o          registered divisor to the clock scaler
//   divisor_load_o     one-cycle pulse accompanying each new divisor
//   irq_o              irq_pending AND irq_enable
// ----------------------------------------------------------------------------
module clock_sweep_sequencer #(
    parameter int SLOTS = 4
) (
    input  logic        input_clock_i,
    input  logic        reset_i,
    input  logic        phi2_i,
    input  logic        enabled_i,
    input  logic [2:0]  register_select_i,
    input  logic        rwb_i,
    input  logic [7:0]  data_bus_r_i,
    output logic [7:0]  data_bus_w_o,
    input  logic        tick_i,
    output logic [15:0] divisor_o,
    output logic        divisor_load_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] REG_SLOT_LO  = 3'd0;
    localparam logic [2:0] REG_SLOT_HI  = 3'd1;
    localparam logic [2:0] REG_HOLD     = 3'd2;
    localparam logic [2:0] REG_CONTROL  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_SLOT_SEL = 3'd5;

    state_t      state_q,       state_d;
    logic [1:0]  slot_q,        slot_d;
    logic [1:0]  slot_sel_q,    slot_sel_d;
    logic [7:0]  latched_lo_q,  latched_lo_d;
    logic [15:0] slot_tbl_q [SLOTS];
    logic [15:0] slot_tbl_d [SLOTS];
    logic [15:0] divisor_q,     divisor_d;
    logic        div_load_q,    div_load_d;
    logic [7:0]  hold_reg_q,    hold_reg_d;
    logic        run_q,         run_d;
    logic        loop_q,        loop_d;
    logic [1:0]  last_slot_q,   last_slot_d;
    logic        irq_en_q,      irq_en_d;
    logic        irq_pend_q,    irq_pend_d;
    logic [7:0]  hold_cnt_q,    hold_cnt_d;
    logic [7:0]  rd_data_q,     rd_data_d;
    logic        phi2_q;

    logic        wr_strobe;
    logic        rd_active;
    logic        ctrl_wr;
    logic        running;
    logic [7:0]  rd_mux;

    // A write fires only on the first phi2-high cycle after a phi2-low cycle,
    // so holding phi2 high across several clocks still acts once.
    assign wr_strobe = enabled_i && !rwb_i && phi2_i && !phi2_q;
    assign rd_active = enabled_i && rwb_i && !phi2_i;
    assign ctrl_wr   = wr_strobe && (register_select_i == REG_CONTROL);
    assign running   = (state_q != ST_IDLE);

    always_comb begin
        rd_mux = 8'h00;
        case (register_select_i)
            REG_SLOT_LO:  rd_mux = slot_tbl_q[slot_sel_q][7:0];
            REG_SLOT_HI:  rd_mux = slot_tbl_q[slot_sel_q][15:8];
            REG_HOLD:     rd_mux = hold_reg_q;
            REG_CONTROL:  rd_mux = {irq_en_q, 3'b000, last_slot_q, loop_q, run_q};
            REG_STATUS:   rd_mux = {irq_pend_q, 4'b0000, slot_q, running};
            REG_SLOT_SEL: rd_mux = {6'b000000, slot_sel_q};
            default:      rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        slot_sel_d   = slot_sel_q;
        latched_lo_d = latched_lo_q;
        slot_tbl_d   = slot_tbl_q;
        divisor_d    = divisor_q;
        div_load_d   = 1'b0;
        hold_reg_d   = hold_reg_q;
        run_d        = run_q;
        loop_d       = loop_q;
        last_slot_d  = last_slot_q;
        irq_en_d     = irq_en_q;
        irq_pend_d   = irq_pend_q;
        hold_cnt_d   = hold_cnt_q;
        rd_data_d    = rd_data_q;

        if (rd_active) begin
            rd_data_d = rd_mux;
        end

        if (wr_strobe) begin
            case (register_select_i)
                REG_SLOT_LO:  latched_lo_d = data_bus_r_i;
                REG_SLOT_HI:  slot_tbl_d[slot_sel_q] = {data_bus_r_i, latched_lo_q};
                REG_HOLD:     hold_reg_d = data_bus_r_i;
                REG_CONTROL: begin
                    run_d       = data_bus_r_i[0];
                    loop_d      = data_bus_r_i[1];
                    last_slot_d = data_bus_r_i[3:2];
                    irq_en_d    = data_bus_r_i[7];
                end
                REG_STATUS:   irq_pend_d = 1'b0;
                REG_SLOT_SEL: slot_sel_d = data_bus_r_i[1:0];
                default: ;
            endcase
        end

        // Sequencer. Any irq set below is assigned after the STATUS clear
        // above, so a same-cycle set wins.
        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && data_bus_r_i[0]) begin
                    slot_d  = 2'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ctrl_wr && !data_bus_r_i[0]) begin
                    state_d = ST_IDLE;
                end else begin
                    divisor_d  = slot_tbl_q[slot_q];
                    div_load_d = 1'b1;
                    hold_cnt_d = hold_reg_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ctrl_wr && !data_bus_r_i[0]) begin
                    state_d = ST_IDLE;
                end else if (tick_i) begin
                    // Counting down from 0 wraps to 255, so HOLD=0 spans 256 ticks.
                    hold_cnt_d = hold_cnt_q - 8'd1;
                    if (hold_cnt_q == 8'd1) begin
                        // last_slot may be lowered mid-sweep; treat any slot at or
                        // beyond it as the final one so slot never runs past 3.
                        if (slot_q < last_slot_q) begin
                            slot_d  = slot_q + 2'd1;
                            state_d = ST_LOAD;
                        end else if (loop_q) begin
                            slot_d     = 2'd0;
                            irq_pend_d = 1'b1;
                            state_d    = ST_LOAD;
                        end else begin
                            irq_pend_d = 1'b1;
                            run_d      = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge input_clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            slot_q       <= 2'd0;
            slot_sel_q   <= 2'd0;
            latched_lo_q <= 8'h00;
            for (int i = 0; i < SLOTS; i++) begin
                slot_tbl_q[i] <= 16'h0002;
            end
            divisor_q    <= 16'h0002;
            div_load_q   <= 1'b0;
            hold_reg_q   <= 8'h01;
            run_q        <= 1'b0;
            loop_q       <= 1'b0;
            last_slot_q  <= 2'd0;
            irq_en_q     <= 1'b0;
            irq_pend_q   <= 1'b0;
            hold_cnt_q   <= 8'h00;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            slot_sel_q   <= slot_sel_d;
            latched_lo_q <= latched_lo_d;
            slot_tbl_q   <= slot_tbl_d;
            divisor_q    <= divisor_d;
            div_load_q   <= div_load_d;
            hold_reg_q   <= hold_reg_d;
            run_q        <= run_d;
            loop_q       <= loop_d;
            last_slot_q  <= last_slot_d;
            irq_en_q     <= irq_en_d;
            irq_pend_q   <= irq_pend_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Phase history for write-edge detection; it just mirrors the bus.
    always_ff @(posedge input_clock_i) begin
        phi2_q <= phi2_i;
    end

    assign data_bus_w_o   = rd_data_q;
    assign divisor_o      = divisor_q;
    assign divisor_load_o = div_load_q;
    assign irq_o          = irq_pend_q && irq_en_q;

endmodule

// File: tb/tb_clock_sweep_sequencer.sv
module tb_clock_sweep_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        phi2 = 1'b0;
    logic        enabled = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic        rwb = 1'b1;
    logic [7:0]  data_r = 8'h00;
    logic [7:0]  data_w;
    logic        tick = 1'b0;
    logic [15:0] divisor;
    logic        divisor_load;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int load_cnt = 0;
    int load_base;
    logic [7:0] rd;
    logic [15:0] tbl_v [4] = '{16'd10, 16'd20, 16'd30, 16'd40};

    always #5 clk = ~clk;

    clock_sweep_sequencer #(.SLOTS(4)) dut (
        .input_clock_i     (clk),
        .reset_i           (reset),
        .phi2_i            (phi2),
        .enabled_i         (enabled),
        .register_select_i (reg_sel),
        .rwb_i             (rwb),
        .data_bus_r_i      (data_r),
        .data_bus_w_o      (data_w),
        .tick_i            (tick),
        .divisor_o         (divisor),
        .divisor_load_o    (divisor_load),
        .irq_o             (irq)
    );

    always @(posedge clk) begin
        #1;
        if (divisor_load) load_cnt++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        enabled = 1'b1; rwb = 1'b0; phi2 = 1'b0; reg_sel = a; data_r = d;
        @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0; enabled = 1'b0; rwb = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        enabled = 1'b1; rwb = 1'b1; phi2 = 1'b0; reg_sel = a;
        @(negedge clk);
        d = data_w;
        enabled = 1'b0;
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [7:0] exp_rd [6];
        exp_rd = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int r = 0; r < 6; r++) begin
            bus_read(3'(r), rd);
            check_eq($sformatf("%s_reg%0d", tag, r), {8'h00, rd}, {8'h00, exp_rd[r]});
        end
    endtask

    initial begin
        // ---- reset defaults
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_data_bus_w", {8'h00, data_w}, 16'h0000);
        check_eq("rst_divisor", divisor, 16'h0002);
        check_eq("rst_irq", {15'd0, irq}, 16'h0000);
        check_eq("rst_divisor_load", {15'd0, divisor_load}, 16'h0000);
        check_reset_regs("rst");

        // read data held while bus idle
        bus_read(3'd2, rd);
        repeat (3) @(negedge clk);
        check_eq("rd_hold_idle", {8'h00, data_w}, 16'h0001);

        // ---- table write, HI strobe held high with data changing
        bus_write(3'd5, 8'h01);
        bus_write(3'd0, 8'h34);
        @(negedge clk);
        enabled = 1'b1; rwb = 1'b0; phi2 = 1'b0; reg_sel = 3'd1; data_r = 8'h12;
        @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        data_r = 8'h99;
        repeat (9) @(negedge clk);
        phi2 = 1'b0; enabled = 1'b0; rwb = 1'b1;
        bus_read(3'd0, rd);
        check_eq("tbl1_lo", {8'h00, rd}, 16'h0034);
        bus_read(3'd1, rd);
        check_eq("tbl1_hi_once", {8'h00, rd}, 16'h0012);
        bus_read(3'd5, rd);
        check_eq("slot_sel_rd", {8'h00, rd}, 16'h0001);
        bus_read(3'd6, rd);
        check_eq("reg6_zero", {8'h00, rd}, 16'h0000);
        bus_write(3'd5, 8'h00);
        bus_read(3'd0, rd);
        check_eq("tbl0_untouched", {8'h00, rd}, 16'h0002);

        // ---- one-shot sweep of 4 slots, HOLD=2
        for (int s = 0; s < 4; s++) begin
            bus_write(3'd5, 8'(s));
            bus_write(3'd0, tbl_v[s][7:0]);
            bus_write(3'd1, tbl_v[s][15:8]);
        end
        bus_write(3'd2, 8'h02);
        load_base = load_cnt;
        bus_write(3'd3, 8'h8D);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("once_div%0d", k), divisor, tbl_v[k]);
            check_eq($sformatf("once_loads%0d", k), 16'(load_cnt - load_base), 16'(k + 1));
            tick_pulse();
            tick_pulse();
        end
        check_eq("once_irq", {15'd0, irq}, 16'h0001);
        repeat (2) @(negedge clk);
        check_eq("once_div_kept", divisor, 16'd40);
        check_eq("once_loads_total", 16'(load_cnt - load_base), 16'd4);
        bus_read(3'd4, rd);
        check_eq("once_status", {8'h00, rd}, 16'h0086);
        bus_read(3'd3, rd);
        check_eq("once_ctrl_run_clr", {8'h00, rd}, 16'h008C);

        // ---- looping sweep
        bus_write(3'd4, 8'h00);
        check_eq("irq_cleared", {15'd0, irq}, 16'h0000);
        load_base = load_cnt;
        bus_write(3'd3, 8'h8F);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("loop_div%0d", k), divisor, tbl_v[k]);
            tick_pulse();
            tick_pulse();
        end
        @(negedge clk);
        check_eq("loop_wrap_div", divisor, 16'd10);
        check_eq("loop_wrap_loads", 16'(load_cnt - load_base), 16'd5);
        check_eq("loop_irq", {15'd0, irq}, 16'h0001);
        tick_pulse();
        tick_pulse();
        bus_write(3'd4, 8'h5A);
        check_eq("loop_irq_clr", {15'd0, irq}, 16'h0000);
        bus_read(3'd4, rd);
        check_eq("loop_status_running", {8'h00, rd}, 16'h0003);
        check_eq("loop_div_slot1", divisor, 16'd20);

        // abort from HOLD
        load_base = load_cnt;
        bus_write(3'd3, 8'h00);
        repeat (2) @(negedge clk);
        check_eq("abort_div", divisor, 16'd20);
        check_eq("abort_no_load", 16'(load_cnt - load_base), 16'd0);
        bus_read(3'd4, rd);
        check_eq("abort_status", {8'h00, rd}, 16'h0002);

        // ---- HOLD=0 means 256 ticks
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h05);
        @(negedge clk);
        check_eq("h256_div0", divisor, 16'd10);
        for (int i = 0; i < 255; i++) tick_pulse();
        @(negedge clk);
        check_eq("h256_div_after255", divisor, 16'd10);
        bus_read(3'd4, rd);
        check_eq("h256_status255", {8'h00, rd}, 16'h0001);
        tick_pulse();
        @(negedge clk);
        check_eq("h256_div_after256", divisor, 16'd20);
        for (int i = 0; i < 5; i++) tick_pulse();
        bus_write(3'd3, 8'h00);
        repeat (2) @(negedge clk);
        check_eq("h256_abort_div", divisor, 16'd20);
        bus_read(3'd4, rd);
        check_eq("h256_abort_status", {8'h00, rd}, 16'h0002);

        // ---- reset during HOLD of slot 2, with a terminal tick alongside
        bus_write(3'd2, 8'h02);
        bus_write(3'd3, 8'h8D);
        for (int i = 0; i < 4; i++) tick_pulse();
        @(negedge clk);
        check_eq("pre_rst_div", divisor, 16'd30);
        tick_pulse();
        bus_read(3'd4, rd);
        check_eq("pre_rst_status", {8'h00, rd}, 16'h0005);
        load_base = load_cnt;
        @(negedge clk);
        reset = 1'b1; tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; tick = 1'b0;
        check_eq("mid_rst_div", divisor, 16'h0002);
        check_eq("mid_rst_load", {15'd0, divisor_load}, 16'h0000);
        check_eq("mid_rst_irq", {15'd0, irq}, 16'h0000);
        check_eq("mid_rst_dbw", {8'h00, data_w}, 16'h0000);
        repeat (3) @(negedge clk);
        check_eq("mid_rst_no_load", 16'(load_cnt - load_base), 16'd0);
        check_reset_regs("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_sweep_sequencer.md
CLOCK_SWEEP_SEQUENCER -- requirements
Module: clock_sweep_sequencer

Interface
REQ-001 SHALL have parameter SLOTS, default 4, number of divisor table entries (index width 2).
REQ-002 SHALL have port input_clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port phi2, input, 1, bus phase: low for read setup, high for write strobe.
REQ-005 SHALL have port enabled, input, 1, device selected on the bus.
REQ-006 SHALL have port register_select, input, 3, register index from the low address bus.
REQ-007 SHALL have port rwb, input, 1, 0 = master writes to the device, 1 = master reads from it.
REQ-008 SHALL have port data_bus_r, input, 8, write data from the bus master.
REQ-009 SHALL have port data_bus_w, output, 8 (registered), read data to the bus master.
REQ-010 SHALL have port tick, input, 1, one-cycle pulse per scaled-clock rising edge, supplied by the clock scaler.
REQ-011 SHALL have port divisor, output, 16 (registered), count-down value driven to the clock scaler.
REQ-012 SHALL have port divisor_load, output, 1, one-cycle pulse asserted when divisor changes.
REQ-013 SHALL have port irq, output, 1, active-high interrupt equal to irq_pending AND irq_enable.

Function
REQ-014 SHALL decode the register map: 0 SLOT_LO (W: latch low byte); 1 SLOT_HI (W: commit {data, latched_lo} to table[slot_sel]); 2 HOLD (R/W, 8-bit ticks per slot, 0 means 256); 3 CONTROL (R/W: bit0 run, bit1 loop, bits3:2 last_slot, bit7 irq_enable); 4 STATUS (R: bit0 running, bits2:1 current slot, bit7 irq_pending; W any value: clear irq_pending); 5 SLOT_SEL (R/W, bits1:0).
REQ-015 SHALL perform each write action once per access, in the first cycle in which enabled=1, rwb=0 and phi2=1 following a cycle with phi2=0.
REQ-016 SHALL, while enabled=1, rwb=1 and phi2=0, register data_bus_w each cycle: reg 0/1 return table[slot_sel] low/high byte; regs 2-5 as mapped; regs 6-7 return 0x00.
REQ-017 SHALL hold data_bus_w unchanged in all other cycles.
REQ-018 SHALL implement states IDLE, LOAD, HOLD.
REQ-019 IDLE: a CONTROL write with bit0=1 SHALL set slot=0 and go to LOAD on the next cycle; running=0 in IDLE.
REQ-020 LOAD (exactly 1 cycle): divisor<=table[slot], divisor_load=1, hold_count<=HOLD, then HOLD.
REQ-021 HOLD: each tick SHALL decrement hold_count (8-bit); on the tick that takes hold_count from 1 to 0 (from 0 it wraps to 255, giving 256 ticks), the slot SHALL end.
REQ-022 At slot end with slot<last_slot: slot<=slot+1, go to LOAD.
REQ-023 At slot end with slot==last_slot and loop=1: slot<=0, go to LOAD, irq_pending<=1.
REQ-024 At slot end with slot==last_slot and loop=0: irq_pending<=1, run bit cleared, go to IDLE; divisor retains its last value.
REQ-025 A CONTROL write with bit0=0 in LOAD or HOLD SHALL abort to IDLE on the next cycle; divisor unchanged; no irq.
REQ-026 A CONTROL write with bit0=1 while running SHALL update loop/last_slot/irq_enable without restarting.
REQ-027 A tick arriving in LOAD or IDLE SHALL be ignored.
REQ-028 If a STATUS clear and an irq set occur in the same cycle, set SHALL win.
REQ-029 A table write to the slot being held SHALL take effect only at that slot's next LOAD.
REQ-030 A HOLD write while running SHALL affect only subsequent LOADs.
REQ-031 last_slot > SLOTS-1 is not reachable with SLOTS=4; wrap of slot beyond 3 SHALL NOT occur.

Reset
REQ-032 reset SHALL force: state IDLE, slot 0, slot_sel 0, latched_lo 0x00, every table entry 0x0002, divisor 0x0002, divisor_load 0, HOLD 0x01, CONTROL 0x00, irq_pending 0, irq 0, data_bus_w 0x00, hold_count 0.
REQ-033 reset asserted mid-sequence SHALL abort the sequence without a divisor_load pulse.
REQ-034 reset SHALL take priority over any simultaneous bus access or tick.

Verification
REQ-035 Reset, then read regs 0-5 -> 0x02, 0x00, 0x01, 0x00, 0x00, 0x00; divisor=0x0002; irq=0.
REQ-036 SLOT_SEL=1, write LO=0x34 and HI=0x12, read back regs 0/1 -> 0x34/0x12; holding phi2 high 10 cycles commits only once.
REQ-037 Table {10,20,30,40}, HOLD=2, CONTROL=0x8D (run, last=3, irq_en), issue 8 ticks -> divisor 10,20,30,40, each with one divisor_load pulse after every 2nd tick; then irq=1 and state IDLE.
REQ-038 Same setup with loop=1 (CONTROL=0x8F), 10 ticks -> divisor returns to 10 after tick 8, irq=1; STATUS write clears irq; running stays 1.
REQ-039 Run with HOLD=0 -> slot advances after exactly 256 ticks; CONTROL=0x00 mid-HOLD -> IDLE, divisor unchanged, no irq.
REQ-040 Assert reset during HOLD of slot 2 -> all REQ-032 values next cycle; no divisor_load pulse.
